// File: rtl/uart_rx_ctrl_if.sv
// Handshake bundle between the UART receiver, this controller and the
// downstream consumer. The controller takes the slave view; whoever drives
// received words and accepts output bytes takes the master view.
interface uart_rx_ctrl_if #(
  parameter int PAYLOAD_BITS = 8
);
  logic                    rx_valid;
  logic                    rx_break;
  logic [PAYLOAD_BITS-1:0] rx_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [PAYLOAD_BITS-1:0] out_data;
  logic                    out_last;

  modport master (
    output rx_valid, rx_break, rx_data, out_ready,
    input  out_valid, out_data, out_last
  );

  modport slave (
    input  rx_valid, rx_break, rx_data, out_ready,
    output out_valid, out_data, out_last
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: enables the UART receiver, stages each received
// byte until its successor (or the end of input) decides its last flag, then
// pushes {last, data} into an output FIFO. End of input is a BREAK, the EOT
// character or an idle timeout; eoi pulses once the FIFO has drained.
module uart_rx_ctrl #(
  parameter int                      PAYLOAD_BITS = 8,
  parameter int                      FIFO_DEPTH   = 16,
  parameter int                      IDLE_TIMEOUT = 120000,
  parameter logic [PAYLOAD_BITS-1:0] EOT_CHAR     = 8'h04
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          enable,
  uart_rx_ctrl_if.slave                 bus,
  output logic                          uart_rx_en,
  output logic                          eoi,
  output logic                          overflow,
  input  logic                          clear_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [AW:0]   PTR_ONE   = 1;
  localparam logic [TW-1:0] TIMER_ONE = 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(IDLE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    DISABLED,
    RUN,
    FLUSH,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [PAYLOAD_BITS-1:0] stagedData_q, stagedData_d;
  logic                    stagedValid_q, stagedValid_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic                    endPending_q, endPending_d;
  logic                    overflow_q;
  logic [AW:0]             wrPtr_q, rdPtr_q;
  logic [PAYLOAD_BITS:0]   mem [FIFO_DEPTH];

  logic                    fifoEmpty, fifoFull, fifoPop, canWrite;
  logic                    fifoWrite, fifoClear, overflowSet;
  logic [PAYLOAD_BITS:0]   fifoWrData, headEntry;
  logic                    rxEnd, idleExpired, endEvent;

  // The extra pointer bit separates full from empty when the indices match.
  assign fifoEmpty = (wrPtr_q == rdPtr_q);
  assign fifoFull  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                     (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign level     = wrPtr_q - rdPtr_q;
  assign fifoPop   = !fifoEmpty && bus.out_ready;
  assign canWrite  = !fifoFull || fifoPop;

  // Head of the FIFO is presented directly; forced to zero while empty.
  assign headEntry     = mem[rdPtr_q[AW-1:0]];
  assign bus.out_valid = !fifoEmpty;
  assign bus.out_data  = fifoEmpty ? '0 : headEntry[PAYLOAD_BITS-1:0];
  assign bus.out_last  = !fifoEmpty && headEntry[PAYLOAD_BITS];

  assign uart_rx_en = (state_q == RUN);
  assign overflow   = overflow_q;

  // BREAK outranks EOT; idle expiry only counts when no word arrives.
  assign rxEnd       = bus.rx_valid && (bus.rx_break || (bus.rx_data == EOT_CHAR));
  assign idleExpired = !bus.rx_valid && stagedValid_q && (timer_q == TIMER_MAX);
  assign endEvent    = rxEnd || idleExpired;

  // Next-state, staging, timer and FIFO-write decisions for each state.
  always_comb begin
    state_d       = state_q;
    stagedData_d  = stagedData_q;
    stagedValid_d = stagedValid_q;
    timer_d       = timer_q;
    endPending_d  = endPending_q;
    fifoWrite     = 1'b0;
    fifoWrData    = '0;
    fifoClear     = 1'b0;
    overflowSet   = 1'b0;
    eoi           = 1'b0;
    unique case (state_q)
      DISABLED: begin
        fifoClear     = 1'b1;
        stagedValid_d = 1'b0;
        timer_d       = '0;
        endPending_d  = 1'b0;
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (!enable) begin
          fifoClear     = 1'b1;
          stagedValid_d = 1'b0;
          timer_d       = '0;
          endPending_d  = 1'b0;
          state_d       = DISABLED;
        end else if (endPending_q) begin
          if (bus.rx_valid) overflowSet = 1'b1;
          if (canWrite) begin
            fifoWrite     = 1'b1;
            fifoWrData    = {1'b1, stagedData_q};
            stagedValid_d = 1'b0;
            endPending_d  = 1'b0;
            timer_d       = '0;
            state_d       = FLUSH;
          end
        end else if (endEvent) begin
          if (!stagedValid_q) begin
            timer_d = '0;
            state_d = FLUSH;
          end else if (canWrite) begin
            fifoWrite     = 1'b1;
            fifoWrData    = {1'b1, stagedData_q};
            stagedValid_d = 1'b0;
            timer_d       = '0;
            state_d       = FLUSH;
          end else begin
            endPending_d = 1'b1;
          end
        end else if (bus.rx_valid) begin
          if (!stagedValid_q) begin
            stagedData_d  = bus.rx_data;
            stagedValid_d = 1'b1;
            timer_d       = '0;
          end else if (canWrite) begin
            fifoWrite    = 1'b1;
            fifoWrData   = {1'b0, stagedData_q};
            stagedData_d = bus.rx_data;
            timer_d      = '0;
          end else begin
            overflowSet = 1'b1;
          end
        end else if (stagedValid_q && (timer_q != TIMER_MAX)) begin
          timer_d = timer_q + TIMER_ONE;
        end
      end
      FLUSH: begin
        if (!enable) begin
          fifoClear     = 1'b1;
          stagedValid_d = 1'b0;
          timer_d       = '0;
          endPending_d  = 1'b0;
          state_d       = DISABLED;
        end else if (fifoEmpty && !stagedValid_q) begin
          eoi     = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!enable) state_d = DISABLED;
      end
      default: state_d = DISABLED;
    endcase
  end

  // Control registers: FSM state, staging slot, idle timer, pending end.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= DISABLED;
      stagedData_q  <= '0;
      stagedValid_q <= 1'b0;
      timer_q       <= '0;
      endPending_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      stagedData_q  <= stagedData_d;
      stagedValid_q <= stagedValid_d;
      timer_q       <= timer_d;
      endPending_q  <= endPending_d;
    end
  end

  // FIFO pointers; a discard wins over any write or pop in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else if (fifoClear) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (fifoWrite) wrPtr_q <= wrPtr_q + PTR_ONE;
      if (fifoPop)   rdPtr_q <= rdPtr_q + PTR_ONE;
    end
  end

  // FIFO storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (fifoWrite && !fifoClear) mem[wrPtr_q[AW-1:0]] <= fifoWrData;
  end

  // Sticky overflow; a new drop beats a simultaneous clear request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow_q <= 1'b0;
    end else if (overflowSet) begin
      overflow_q <= 1'b1;
    end else if (clear_overflow) begin
      overflow_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: a queue-based model of the byte stream is checked
// against the DUT every cycle, directed scenarios pin key behaviours with
// literal values, and a randomized phase exercises mixed traffic.
module tb_uart_rx_ctrl;

  localparam int   DEPTH = 16;
  localparam int   TOUT  = 50;
  localparam logic [7:0] EOT = 8'h04;
  localparam int   M_DIS   = 0;
  localparam int   M_RUN   = 1;
  localparam int   M_FLUSH = 2;
  localparam int   M_DONE  = 3;

  logic       clk = 1'b0;
  logic       resetn;
  logic       enable;
  logic       clear_overflow;
  logic       uart_rx_en;
  logic       eoi;
  logic       overflow;
  logic [4:0] level;

  uart_rx_ctrl_if #(.PAYLOAD_BITS(8)) bus();

  uart_rx_ctrl #(
    .PAYLOAD_BITS(8),
    .FIFO_DEPTH(DEPTH),
    .IDLE_TIMEOUT(TOUT),
    .EOT_CHAR(EOT)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .enable(enable),
    .bus(bus),
    .uart_rx_en(uart_rx_en),
    .eoi(eoi),
    .overflow(overflow),
    .clear_overflow(clear_overflow),
    .level(level)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;
  int cyc     = 0;
  int eoiCount = 0;
  int lastEoiCyc = 0;
  int lastPopCyc = 0;
  logic [8:0] dutLog[$];
  bit randReady = 0;
  bit randClear = 0;

  // Model state: FIFO contents as {last, data}, staged byte, idle count.
  logic [8:0] mq[$];
  int         mMode = M_DIS;
  bit         mStaged = 0;
  logic [7:0] mStagedData = '0;
  int         mIdle = 0;
  bit         mPend = 0;
  bit         mOvf = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; inputs change 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (randReady) bus.out_ready = ($urandom_range(0, 1) == 1);
    if (randClear) clear_overflow = ($urandom_range(0, 15) == 0);
  endtask

  // One-cycle rx_valid pulse carrying a word (or a BREAK).
  task automatic applyStimulus(input logic [7:0] d, input bit brk);
    bus.rx_valid = 1'b1;
    bus.rx_break = brk;
    bus.rx_data  = d;
    tick();
    bus.rx_valid = 1'b0;
    bus.rx_break = 1'b0;
    bus.rx_data  = '0;
  endtask

  function automatic logic [7:0] randByte();
    logic [7:0] v;
    v = 8'($urandom_range(0, 255));
    if (v == EOT) v = 8'h5A;
    return v;
  endfunction

  task automatic startStream();
    enable = 1'b0;
    repeat (2) tick();
    dutLog.delete();
    enable = 1'b1;
    tick();
  endtask

  task automatic waitEoi(input string name, input int bound);
    int base = eoiCount;
    bit got = 0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (eoiCount > base) begin
        got = 1;
        break;
      end
    end
    checkOutput(name, 32'(got), 32'd1);
  endtask

  // Reference behaviour of the stream, advanced on every rising edge.
  always @(posedge clk or negedge resetn) begin : model
    bit pop, canW, wr, ovfSet, isEnd, discard;
    logic [8:0] wEntry;
    if (!resetn) begin
      mq.delete();
      mMode = M_DIS;
      mStaged = 0;
      mIdle = 0;
      mPend = 0;
      mOvf = 0;
    end else begin
      pop = (mq.size() != 0) && bus.out_ready;
      canW = (mq.size() < DEPTH) || pop;
      wr = 0;
      ovfSet = 0;
      discard = 0;
      wEntry = '0;
      isEnd = bus.rx_valid && (bus.rx_break || bus.rx_data == EOT);
      case (mMode)
        M_DIS: if (enable) mMode = M_RUN;
        M_RUN: begin
          if (!enable) begin
            discard = 1;
          end else if (mPend) begin
            if (bus.rx_valid) ovfSet = 1;
            if (canW) begin
              wr = 1; wEntry = {1'b1, mStagedData};
              mStaged = 0; mPend = 0; mMode = M_FLUSH;
            end
          end else if (isEnd || (!bus.rx_valid && mStaged && mIdle >= TOUT - 1)) begin
            if (!mStaged) mMode = M_FLUSH;
            else if (canW) begin
              wr = 1; wEntry = {1'b1, mStagedData};
              mStaged = 0; mMode = M_FLUSH;
            end else mPend = 1;
          end else if (bus.rx_valid) begin
            if (!mStaged) begin
              mStaged = 1; mStagedData = bus.rx_data; mIdle = 0;
            end else if (canW) begin
              wr = 1; wEntry = {1'b0, mStagedData};
              mStagedData = bus.rx_data; mIdle = 0;
            end else ovfSet = 1;
          end else if (mStaged && mIdle < TOUT - 1) begin
            mIdle = mIdle + 1;
          end
        end
        M_FLUSH: begin
          if (!enable) discard = 1;
          else if (mq.size() == 0) mMode = M_DONE;
        end
        default: if (!enable) mMode = M_DIS;
      endcase
      if (discard) begin
        mq.delete();
        mStaged = 0; mPend = 0; mIdle = 0;
        mMode = M_DIS;
      end else begin
        if (pop) void'(mq.pop_front());
        if (wr) mq.push_back(wEntry);
      end
      if (ovfSet) mOvf = 1;
      else if (clear_overflow) mOvf = 0;
    end
  end

  // Compare DUT outputs with the model on every falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!resetn) begin
      checkOutput("rst_uart_rx_en", 32'(uart_rx_en), 32'd0);
      checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("rst_level", 32'(level), 32'd0);
      checkOutput("rst_overflow", 32'(overflow), 32'd0);
      checkOutput("rst_eoi", 32'(eoi), 32'd0);
    end else begin
      checkOutput("uart_rx_en", 32'(uart_rx_en), 32'(mMode == M_RUN));
      checkOutput("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
      checkOutput("level", 32'(level), 32'(mq.size()));
      checkOutput("overflow", 32'(overflow), 32'(mOvf));
      checkOutput("eoi", 32'(eoi), 32'(mMode == M_FLUSH && mq.size() == 0 && enable));
      if (mq.size() != 0) begin
        checkOutput("out_data", 32'(bus.out_data), 32'(mq[0][7:0]));
        checkOutput("out_last", 32'(bus.out_last), 32'(mq[0][8]));
      end
      if (eoi) begin
        eoiCount++;
        lastEoiCyc = cyc;
      end
      if (bus.out_valid && bus.out_ready) begin
        dutLog.push_back({bus.out_last, bus.out_data});
        lastPopCyc = cyc;
      end
    end
  end

  // Hard stop in case something never terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios followed by randomized streams.
  initial begin
    logic [7:0] b[20];
    int found;
    int base;
    int sel;
    resetn = 1'b0;
    enable = 1'b0;
    clear_overflow = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_break = 1'b0;
    bus.rx_data = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    checkOutput("reset_uart_rx_en", 32'(uart_rx_en), 32'd0);
    checkOutput("reset_level", 32'(level), 32'd0);
    checkOutput("reset_out_data", 32'(bus.out_data), 32'd0);
    resetn = 1'b1;
    tick();

    $display("[TB] scenario: A B C then EOT");
    startStream();
    bus.out_ready = 1'b1;
    base = eoiCount;
    applyStimulus(8'h41, 0);
    applyStimulus(8'h42, 0);
    applyStimulus(8'h43, 0);
    applyStimulus(EOT, 0);
    waitEoi("t1_eoi_seen", 20);
    repeat (3) tick();
    checkOutput("t1_count", 32'(dutLog.size()), 32'd3);
    checkOutput("t1_byte0", 32'(dutLog[0]), 32'h041);
    checkOutput("t1_byte1", 32'(dutLog[1]), 32'h042);
    checkOutput("t1_byte2", 32'(dutLog[2]), 32'h143);
    checkOutput("t1_eoi_after_pop", 32'(lastEoiCyc - lastPopCyc), 32'd1);
    checkOutput("t1_eoi_once", 32'(eoiCount - base), 32'd1);
    checkOutput("t1_rx_en_off", 32'(uart_rx_en), 32'd0);

    $display("[TB] scenario: idle timeout");
    startStream();
    bus.out_ready = 1'b1;
    applyStimulus(8'h31, 0);
    applyStimulus(8'h0A, 0);
    found = -1;
    for (int i = 0; i < TOUT + 10; i++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_last) begin
        found = i;
        break;
      end
    end
    checkOutput("t2_timeout_cycle", 32'(found), 32'(TOUT));
    checkOutput("t2_last_data", 32'(bus.out_data), 32'h0A);
    checkOutput("t2_rx_en_off", 32'(uart_rx_en), 32'd0);
    waitEoi("t2_eoi_seen", 20);
    checkOutput("t2_first", 32'(dutLog[0]), 32'h031);

    $display("[TB] scenario: overflow with stalled consumer");
    startStream();
    bus.out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      b[i] = randByte();
      applyStimulus(b[i], 0);
      tick();
    end
    checkOutput("t3_level_full", 32'(level), 32'(DEPTH));
    checkOutput("t3_overflow_set", 32'(overflow), 32'd1);
    bus.out_ready = 1'b1;
    repeat (20) tick();
    checkOutput("t3_drained", 32'(dutLog.size()), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput($sformatf("t3_byte%0d", i), 32'(dutLog[i]), 32'({1'b0, b[i]}));
    end
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    checkOutput("t3_overflow_clear", 32'(overflow), 32'd0);
    applyStimulus(EOT, 0);
    waitEoi("t3_eoi_seen", 20);
    checkOutput("t3_staged_last", 32'(dutLog[DEPTH]), 32'({1'b1, b[DEPTH]}));

    $display("[TB] scenario: BREAK ends the input");
    startStream();
    bus.out_ready = 1'b1;
    b[0] = randByte();
    b[1] = randByte();
    applyStimulus(b[0], 0);
    applyStimulus(b[1], 0);
    applyStimulus(8'h00, 1);
    waitEoi("t4_eoi_seen", 20);
    checkOutput("t4_count", 32'(dutLog.size()), 32'd2);
    checkOutput("t4_byte0", 32'(dutLog[0]), 32'({1'b0, b[0]}));
    checkOutput("t4_byte1", 32'(dutLog[1]), 32'({1'b1, b[1]}));

    $display("[TB] scenario: disable mid-stream");
    startStream();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) applyStimulus(randByte(), 0);
    checkOutput("t5_level5", 32'(level), 32'd5);
    base = eoiCount;
    enable = 1'b0;
    repeat (3) tick();
    checkOutput("t5_level0", 32'(level), 32'd0);
    checkOutput("t5_no_eoi", 32'(eoiCount - base), 32'd0);
    checkOutput("t5_rx_en_off", 32'(uart_rx_en), 32'd0);
    dutLog.delete();
    enable = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    applyStimulus(8'h55, 0);
    applyStimulus(8'h66, 0);
    applyStimulus(EOT, 0);
    waitEoi("t5_eoi_seen", 20);
    checkOutput("t5_count", 32'(dutLog.size()), 32'd2);
    checkOutput("t5_byte0", 32'(dutLog[0]), 32'h055);
    checkOutput("t5_byte1", 32'(dutLog[1]), 32'h166);

    $display("[TB] scenario: pop and write while full, then async reset");
    startStream();
    bus.out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      b[i] = randByte();
      applyStimulus(b[i], 0);
    end
    checkOutput("t6_level_full", 32'(level), 32'(DEPTH));
    bus.out_ready = 1'b1;
    applyStimulus(randByte(), 0);
    bus.out_ready = 1'b0;
    checkOutput("t6_level_kept", 32'(level), 32'(DEPTH));
    checkOutput("t6_no_overflow", 32'(overflow), 32'd0);
    checkOutput("t6_popped", 32'(dutLog[0]), 32'({1'b0, b[0]}));
    applyStimulus(randByte(), 0);
    checkOutput("t6_overflow_drop", 32'(overflow), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("t6_async_rx_en", 32'(uart_rx_en), 32'd0);
    checkOutput("t6_async_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("t6_async_level", 32'(level), 32'd0);
    checkOutput("t6_async_overflow", 32'(overflow), 32'd0);
    checkOutput("t6_async_data", 32'(bus.out_data), 32'd0);
    tick();
    resetn = 1'b1;
    tick();

    $display("[TB] randomized streams");
    randReady = 1;
    randClear = 1;
    for (int s = 0; s < 40; s++) begin
      startStream();
      for (int k = 0; k < int'($urandom_range(0, 24)); k++) begin
        if ($urandom_range(0, 19) == 0) repeat ($urandom_range(40, 60)) tick();
        else repeat ($urandom_range(0, 3)) tick();
        applyStimulus(8'($urandom_range(0, 255)), 0);
      end
      sel = int'($urandom_range(0, 3));
      if (sel == 0) applyStimulus(EOT, 0);
      else if (sel == 1) applyStimulus(8'h00, 1);
      else if (sel == 2) begin
        repeat (TOUT + 10) tick();
        if (mMode == M_RUN) applyStimulus(EOT, 0);
      end else enable = 1'b0;
      found = 0;
      for (int i = 0; i < 3000; i++) begin
        if (mMode == M_DONE || mMode == M_DIS) begin
          found = 1;
          break;
        end
        tick();
      end
      checkOutput("rand_stream_end", 32'(found), 32'd1);
    end
    randReady = 0;
    randClear = 0;
    clear_overflow = 1'b0;
    enable = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side controller for the UART receiver. Enables the receiver, collects received bytes into a FIFO with a ready/valid output, and detects end-of-input.
- End-of-input is a BREAK, an EOT character, or an idle timeout. The last byte of the input is tagged with out_last and eoi pulses when the stream is fully drained.
- Sits between the UART receiver and the puzzle-solver datapath.

Parameters:
PAYLOAD_BITS, 8, data width of each received word
FIFO_DEPTH, 16, output FIFO entries; power of two, at least 2
IDLE_TIMEOUT, 120000, idle clock cycles after the last byte that end the input
EOT_CHAR, 8'h04, end-of-transmission character; consumed, never stored

Ports:
clk  in  1  system clock
resetn  in  1  reset, asynchronous, active-low
enable  in  1  run request; level-sensitive
rx_valid  in  1  one-cycle pulse from the receiver: word received
rx_break  in  1  receiver BREAK flag; qualified by rx_valid
rx_data  in  PAYLOAD_BITS  received word
uart_rx_en  out  1  receiver enable
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer ready; pop when out_valid && out_ready
out_data  out  PAYLOAD_BITS  FIFO head data
out_last  out  1  FIFO head is the final byte of the input
eoi  out  1  one-cycle pulse: input ended and fully drained
overflow  out  1  sticky: a byte was dropped
clear_overflow  in  1  clears overflow; the set condition wins if both happen in the same cycle
level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy, 0..FIFO_DEPTH

Behaviour:
- Reset state:
  - state = DISABLED; FIFO and staging register empty; timer = 0.
  - All outputs are 0, including uart_rx_en.
- Storage:
  - FIFO entries are {last, data}, PAYLOAD_BITS+1 bits wide.
  - A one-entry staging register holds the most recent byte so that its last flag can be decided before it is written to the FIFO.
- FSM states: DISABLED, RUN, FLUSH, DONE.
- DISABLED:
  - uart_rx_en = 0. FIFO, staging and timer are held cleared.
  - enable=1 -> RUN on the next clock.
- RUN:
  - uart_rx_en = 1.
  - Data byte (rx_valid && !rx_break && rx_data != EOT_CHAR):
    - If staging is occupied, the staged byte is written to the FIFO with last=0 in the same cycle.
    - The new byte is loaded into staging and the timer resets to 0.
  - End event: rx_valid && rx_break, OR rx_valid && rx_data == EOT_CHAR, OR timer == IDLE_TIMEOUT-1 with staging occupied.
    - The staged byte, if any, is written with last=1; then the FSM goes to FLUSH.
    - With staging empty, the FSM goes directly to FLUSH. No last-tagged entry exists, and eoi still follows.
  - Timer:
    - Increments each RUN cycle while staging is occupied and no rx_valid arrives.
    - Saturates at IDLE_TIMEOUT-1.
    - Does not run before the first byte, so idle before any data never ends the input.
  - Priority: rx_break beats the EOT check, which beats the data path. A BREAK word (data 0) is never stored.
- FIFO write when full:
  - A write is accepted if a pop occurs in the same cycle.
  - Otherwise the staged byte is kept in staging, the incoming byte is dropped, and overflow is set.
  - An end event while full and not popping holds the FSM in RUN-pending. The last=1 write retries each cycle until it is accepted. Further rx_valid pulses are dropped and set overflow.
- FLUSH:
  - uart_rx_en = 0. Pops continue.
  - When the FIFO is empty (level==0) and staging is empty: eoi=1 for exactly one cycle, then DONE.
- DONE:
  - uart_rx_en = 0. Outputs idle.
  - enable=0 -> DISABLED.
- enable=0 in RUN or FLUSH:
  - Next state is DISABLED. FIFO and staging are discarded, and no eoi is generated.
  - overflow is unaffected.
- Latency:
  - A byte written to the FIFO at edge N appears at out_valid/out_data after edge N.
  - A data byte therefore becomes visible one FIFO write after the next byte or the end event.
- Outputs:
  - out_data and out_last are registered/FIFO-read values, stable while out_valid && !out_ready.
  - level updates every clock: +1 on write only, -1 on pop only, unchanged on both or neither.
- Pointers: wrap modulo FIFO_DEPTH. Full/empty are distinguished by an extra pointer bit.
- Async reset mid-operation: immediately returns the block to the reset state, including clearing overflow.

Test Plan:
- enable=1; pulses 'A','B','C', then EOT (0x04); out_ready=1 -> out_data 0x41,0x42,0x43 with out_last only on 0x43; eoi one cycle after the 0x43 pop; EOT never output; state DONE.
- Bytes 0x31,0x0A, then silence for IDLE_TIMEOUT cycles -> 0x0A emitted with last=1 exactly at the timeout; uart_rx_en drops; eoi after drain.
- out_ready=0; send FIFO_DEPTH+3 bytes -> level saturates at FIFO_DEPTH; overflow=1; out_ready=1 -> first FIFO_DEPTH bytes come out intact and in order; clear_overflow -> overflow=0.
- rx_valid with rx_break=1, rx_data=0 after 2 bytes -> second byte is tagged last; 0x00 is never stored; eoi is generated.
- enable=0 mid-RUN with 5 bytes buffered -> DISABLED, level=0, no eoi; re-enable -> a clean new stream works.
- Pop and write in the same cycle with the FIFO full -> level stays at FIFO_DEPTH, no overflow; resetn asserted mid-stream -> all outputs 0 asynchronously.
